// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: bus request/response
// structs, the fetch FSM state encoding and the default reset vector.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction bus between the fetch controller (master) and memory (slave).
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  ibus_req_t  req;
  ibus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch FSM with redirect handling and
// misaligned-PC exception delivery.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  fetch_ctrl_if.master ibus,
  input  logic         stall_in,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  output logic [31:0]  pc_out,
  output logic [31:0]  instr_out,
  output logic         addr_error,
  output logic [31:0]  bad_vaddr,
  output logic         fetch_stall
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  instr_out_q, instr_out_d;
  logic         addr_error_q, addr_error_d;
  logic [31:0]  bad_vaddr_q, bad_vaddr_d;
  logic [31:0]  flush_pc_s;
  logic         rsp_done_s;
  ibus_req_t    req_s;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;
    instr_valid_d = instr_valid_q;
    pc_out_d      = pc_out_q;
    instr_out_d   = instr_out_q;
    addr_error_d  = addr_error_q;
    bad_vaddr_d   = bad_vaddr_q;
    // A redirect in the completion cycle beats any earlier latched target.
    flush_pc_s    = redirect ? redirect_pc : pend_pc_q;
    rsp_done_s    = ibus.resp.data_ok && ((state_q == ST_WAIT) || ibus.resp.addr_ok);

    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (misaligned(pc_q)) begin
          state_d       = ST_HOLD;
          instr_valid_d = 1'b1;
          pc_out_d      = pc_q;
          instr_out_d   = 32'd0;
          addr_error_d  = 1'b1;
          bad_vaddr_d   = pc_q;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_REQ, ST_WAIT: begin
        if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end else begin
          pend_d    = pend_q;
        end
        // The bus transaction always runs to completion; only its data is dropped.
        if (rsp_done_s) begin
          if (redirect || pend_q) begin
            state_d = ST_IDLE;
            pc_d    = flush_pc_s;
            pend_d  = 1'b0;
          end else begin
            state_d       = ST_HOLD;
            instr_valid_d = 1'b1;
            pc_out_d      = pc_q;
            instr_out_d   = ibus.resp.data;
            addr_error_d  = 1'b0;
            bad_vaddr_d   = 32'd0;
          end
        end else if ((state_q == ST_REQ) && ibus.resp.addr_ok) begin
          state_d = ST_WAIT;
        end else begin
          state_d = state_q;
        end
      end

      ST_HOLD: begin
        if (redirect || !stall_in) begin
          state_d       = ST_IDLE;
          pc_d          = redirect ? redirect_pc : pc_q + 32'd4;
          instr_valid_d = 1'b0;
          addr_error_d  = 1'b0;
          bad_vaddr_d   = 32'd0;
        end else begin
          instr_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_pc_q     <= 32'd0;
      instr_valid_q <= 1'b0;
      pc_out_q      <= RESET_PC;
      instr_out_q   <= 32'd0;
      addr_error_q  <= 1'b0;
      bad_vaddr_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
      instr_out_q   <= instr_out_d;
      addr_error_q  <= addr_error_d;
      bad_vaddr_q   <= bad_vaddr_d;
    end
  end

  always_comb begin
    req_s.valid = (state_q == ST_REQ);
    req_s.addr  = (state_q == ST_REQ) ? pc_q : 32'd0;
  end

  assign ibus.req    = req_s;
  assign fetch_stall = (state_q == ST_REQ) || (state_q == ST_WAIT) || pend_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
  assign instr_out   = instr_out_q;
  assign addr_error  = addr_error_q;
  assign bad_vaddr   = bad_vaddr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a behavioural memory slave plus a
// program-order model of which PC must be fetched and delivered next.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        addr_error;
  logic [31:0] bad_vaddr;
  logic        fetch_stall;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: architectural next PC, delivered-data expectations, slave state.
  logic [31:0] exp_pc;
  logic        have_fetch;
  logic [31:0] fetch_data;
  logic        outst;
  logic [31:0] out_addr;
  int          dly;
  logic        live;
  logic        prev_wait;
  logic [31:0] prev_addr;
  int          idle_run;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ibus        (bus),
    .stall_in    (stall_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .addr_error  (addr_error),
    .bad_vaddr   (bad_vaddr),
    .fetch_stall (fetch_stall)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check_val("rst_req_valid", 32'(bus.req.valid), 32'd0);
    check_val("rst_req_addr", bus.req.addr, 32'd0);
    check_val("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_val("rst_pc_out", pc_out, RST_PC);
    check_val("rst_instr_out", instr_out, 32'd0);
    check_val("rst_addr_error", 32'(addr_error), 32'd0);
    check_val("rst_bad_vaddr", bad_vaddr, 32'd0);
    check_val("rst_fetch_stall", 32'(fetch_stall), 32'd0);
  endtask

  task automatic model_reset();
    exp_pc     = RST_PC;
    have_fetch = 1'b0;
    fetch_data = 32'd0;
    outst      = 1'b0;
    out_addr   = 32'd0;
    dly        = 0;
    live       = 1'b0;
    prev_wait  = 1'b0;
    prev_addr  = 32'd0;
    idle_run   = 0;
  endtask

  // One clock cycle: check outputs, pick inputs, advance the model.
  task automatic step();
    logic        v;
    logic [31:0] a;
    logic        aok;
    logic        dok;
    logic [31:0] dat;
    logic [31:0] txn_addr;
    logic [31:0] r;
    v = bus.req.valid;
    a = bus.req.addr;

    if (prev_wait) begin
      check_val("req_hold_valid", 32'(v), 32'd1);
      check_val("req_hold_addr", a, prev_addr);
    end else if (v) begin
      check_val("req_addr", a, exp_pc);
    end
    if (v) check_val("req_aligned", {30'd0, a[1:0]}, 32'd0);
    check_val("fetch_stall", 32'(fetch_stall), 32'(v || outst));
    if (exp_pc[1:0] == 2'b00) check_val("instr_valid", 32'(instr_valid), 32'(have_fetch));
    if (instr_valid) begin
      check_val("pc_out", pc_out, exp_pc);
      if (exp_pc[1:0] == 2'b00) begin
        check_val("instr_out", instr_out, fetch_data);
        check_val("addr_error_clr", 32'(addr_error), 32'd0);
      end else begin
        check_val("addr_error_set", 32'(addr_error), 32'd1);
        check_val("bad_vaddr", bad_vaddr, exp_pc);
        check_val("instr_out_exc", instr_out, 32'd0);
      end
    end
    if (!addr_error) check_val("bad_vaddr_zero", bad_vaddr, 32'd0);
    idle_run = (!v && !outst && !instr_valid) ? idle_run + 1 : 0;
    check_val("idle_gap", 32'(idle_run > 1), 32'd0);

    stall_in = ($urandom_range(0, 2) == 0);
    redirect = ($urandom_range(0, 9) == 0);
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       redirect_pc = 32'hffff_fffc;
      1:       redirect_pc = {r[31:2], 2'($urandom_range(1, 3))};
      2:       redirect_pc = 32'h8000_0100;
      3:       redirect_pc = 32'h8000_0102;
      default: redirect_pc = {r[31:2], 2'b00};
    endcase
    aok = v && !outst && ($urandom_range(0, 1) == 1);
    dok = 1'b0;
    txn_addr = a;
    if (outst) begin
      dok = (dly == 0);
      txn_addr = out_addr;
    end else if (aok) begin
      dok = ($urandom_range(0, 2) == 0);
    end
    dat = $urandom;
    bus.resp = '{addr_ok: aok, data_ok: dok, data: dat};

    if (v && !prev_wait) live = 1'b1;
    if (redirect && (v || outst)) live = 1'b0;
    if (redirect) begin
      exp_pc = redirect_pc;
      have_fetch = 1'b0;
      idle_run = 0;
    end else if (instr_valid && !stall_in) begin
      exp_pc = exp_pc + 32'd4;
      have_fetch = 1'b0;
    end
    if (dok && live && (txn_addr == exp_pc)) begin
      have_fetch = 1'b1;
      fetch_data = dat;
    end
    if (dok) live = 1'b0;
    if (outst) begin
      if (dok) outst = 1'b0;
      else dly--;
    end else if (aok && !dok) begin
      outst = 1'b1;
      out_addr = a;
      dly = $urandom_range(0, 3);
    end
    prev_wait = v && !aok;
    prev_addr = a;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      step();
      @(posedge clk);
    end
  endtask

  task automatic apply_reset(input logic stray_data_ok);
    @(negedge clk);
    resetn = 1'b0;
    stall_in = 1'b0;
    redirect = 1'b0;
    bus.resp = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'd0};
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    // A late response from the abandoned transaction must be ignored.
    bus.resp = '{addr_ok: 1'b0, data_ok: stray_data_ok, data: 32'hdead_beef};
    @(posedge clk);
  endtask

  initial begin
    bus.resp = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'd0};
    model_reset();
    apply_reset(1'b0);
    run_cycles(2000);
    apply_reset(1'b1);
    run_cycles(2000);
    apply_reset(1'b1);
    run_cycles(2000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
